// File: rtl/seq_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl_if
// Description : Handshake/status bundle between the SEQ sequencer and the
//               fetch/memory/stage logic around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_stage_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             start;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             dmem_error;
  logic             mem_ready;
  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             memory_en;
  logic             writeback_en;
  logic             pc_en;
  logic [2:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] retired;

  // Environment side: drives control/fetch/memory inputs, observes outputs.
  modport master (
    output start, icode, instr_valid, imem_error, dmem_error, mem_ready,
    input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
    input  stat, busy, retired
  );

  // Sequencer side.
  modport slave (
    input  start, icode, instr_valid, imem_error, dmem_error, mem_ready,
    output fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
    output stat, busy, retired
  );
endinterface
`default_nettype wire

// File: rtl/seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_stage_ctrl
// Description : Multi-cycle Y86-64 SEQ sequencer. Walks FETCH..PCUPD one
//               stage per cycle, waits on data-memory ready with a timeout,
//               tracks processor status and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stage_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire              clk,
  input  wire              reset,
  seq_stage_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALTED    = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [3:0]        icode_q, icode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_op;
  logic [WAIT_W-1:0] wait_inc;

  // rmmovq, mrmovq, call, ret, pushq, popq touch data memory.
  assign mem_op = (icode_q == 4'd4) || (icode_q == 4'd5) || (icode_q == 4'd8) ||
                  (icode_q == 4'd9) || (icode_q == 4'd10) || (icode_q == 4'd11);

  // Saturating wait-counter increment so the counter can never wrap.
  assign wait_inc = (wait_q == C_TIMEOUT) ? wait_q : (wait_q + C_WAIT_ONE);

  // Next-state, status, retire and wait-counter logic.
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    icode_d   = icode_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (!bus.instr_valid || (bus.icode > 4'd11)) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else if (bus.icode == 4'd0) begin
          // halt retires even though no later stage runs
          stat_d    = STAT_HLT;
          retired_d = retired_q + C_CNT_ONE;
          state_d   = S_HALTED;
        end else begin
          icode_d = bus.icode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (mem_op) begin
          wait_d  = '0;
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == C_TIMEOUT) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        retired_d = retired_q + C_CNT_ONE;
        state_d   = bus.start ? S_FETCH : S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
      icode_q   <= 4'd0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
      icode_q   <= icode_d;
      wait_q    <= wait_d;
    end
  end

  // Moore outputs decoded straight from the registered state.
  assign bus.fetch_en     = (state_q == S_FETCH);
  assign bus.decode_en    = (state_q == S_DECODE);
  assign bus.execute_en   = (state_q == S_EXECUTE);
  assign bus.memory_en    = (state_q == S_MEMORY);
  assign bus.writeback_en = (state_q == S_WRITEBACK);
  assign bus.pc_en        = (state_q == S_PCUPD);
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign bus.stat         = stat_q;
  assign bus.retired      = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_stage_ctrl
// Description : Directed self-checking bench for seq_stage_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stage_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  seq_stage_ctrl_if #(.CNT_W(32)) bus ();

  seq_stage_ctrl #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fetch, decode, execute, memory, writeback, pc}
  logic [5:0] en;
  assign en = {bus.fetch_en, bus.decode_en, bus.execute_en,
               bus.memory_en, bus.writeback_en, bus.pc_en};

  localparam logic [5:0] E_F = 6'b100000;
  localparam logic [5:0] E_D = 6'b010000;
  localparam logic [5:0] E_E = 6'b001000;
  localparam logic [5:0] E_M = 6'b000100;
  localparam logic [5:0] E_W = 6'b000010;
  localparam logic [5:0] E_P = 6'b000001;
  localparam logic [5:0] E_0 = 6'b000000;

  logic [5:0] mr_tbl  [9]  = '{E_F, E_D, E_E, E_M, E_M, E_M, E_M, E_W, E_P};
  logic [5:0] b2b_tbl [13] = '{E_F, E_D, E_E, E_W, E_P,
                               E_F, E_D, E_E, E_M, E_W, E_P,
                               E_F, E_0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.icode       = 4'd0;
    bus.instr_valid = 1'b0;
    bus.imem_error  = 1'b0;
    bus.dmem_error  = 1'b0;
    bus.mem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int mem_cnt, wb_cnt, pc_cnt;

  initial begin
    n_cmp = 0;
    n_err = 0;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_en", en, E_0);
    check("rst_stat", bus.stat, 3'd1);
    check("rst_ret", bus.retired, 0);
    check("rst_busy", bus.busy, 1'b0);

    // ---------------- OPq: five stages, no memory ----------------
    bus.icode = 4'd6; bus.instr_valid = 1'b1; bus.start = 1'b1;
    tick(); check("opq_f", en, E_F); check("opq_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    tick(); check("opq_d", en, E_D);
    tick(); check("opq_e", en, E_E);
    tick(); check("opq_w", en, E_W);
    tick(); check("opq_p", en, E_P);
    tick(); check("opq_idle", en, E_0);
    check("opq_busy0", bus.busy, 1'b0);
    check("opq_ret", bus.retired, 1);
    check("opq_stat", bus.stat, 3'd1);

    // ---------------- mrmovq with 3 wait cycles ----------------
    do_reset();
    bus.icode = 4'd5; bus.instr_valid = 1'b1; bus.start = 1'b1;
    mem_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) bus.start = 1'b0;
      check($sformatf("mr_c%0d", i), en, mr_tbl[i]);
      if (bus.memory_en) mem_cnt++;
      // dmem_error is noise while not ready, clean when ready
      bus.mem_ready  = (i == 6);
      bus.dmem_error = (i != 6);
    end
    bus.mem_ready = 1'b0; bus.dmem_error = 1'b0;
    tick();
    check("mr_idle", en, E_0);
    check("mr_memcnt", mem_cnt, 4);
    check("mr_ret", bus.retired, 1);
    check("mr_stat", bus.stat, 3'd1);

    // ---------------- pushq timeout ----------------
    do_reset();
    bus.icode = 4'd10; bus.instr_valid = 1'b1; bus.start = 1'b1;
    mem_cnt = 0; wb_cnt = 0; pc_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 0) bus.start = 1'b0;
      if (bus.memory_en) mem_cnt++;
      if (bus.writeback_en) wb_cnt++;
      if (bus.pc_en) pc_cnt++;
      if (i == 17) check("to_last_mem", en, E_M);
      if (i == 18) check("to_halt_en", en, E_0);
    end
    check("to_memcnt", mem_cnt, 15);
    check("to_wb", wb_cnt, 0);
    check("to_pc", pc_cnt, 0);
    check("to_stat", bus.stat, 3'd3);
    check("to_busy", bus.busy, 1'b0);
    check("to_ret", bus.retired, 0);

    // ---------------- back-to-back 3, 11, 0 ----------------
    do_reset();
    bus.icode = 4'd3; bus.instr_valid = 1'b1; bus.mem_ready = 1'b1; bus.start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("b2b_c%0d", i), en, b2b_tbl[i]);
      if (i == 4)  bus.icode = 4'd11;
      if (i == 10) bus.icode = 4'd0;
    end
    check("b2b_stat", bus.stat, 3'd2);
    check("b2b_ret", bus.retired, 3);
    check("b2b_busy", bus.busy, 1'b0);
    bus.start = 1'b0; tick();
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
    check("b2b_hold_en", en, E_0);
    check("b2b_hold_stat", bus.stat, 3'd2);
    check("b2b_hold_ret", bus.retired, 3);

    // ---------------- FETCH faults ----------------
    do_reset();
    bus.imem_error = 1'b1; bus.instr_valid = 1'b0; bus.icode = 4'd6; bus.start = 1'b1;
    tick(); check("adr_f", en, E_F);
    tick(); check("adr_en", en, E_0);
    check("adr_stat", bus.stat, 3'd3);
    check("adr_ret", bus.retired, 0);

    do_reset();
    bus.icode = 4'd12; bus.instr_valid = 1'b1; bus.start = 1'b1;
    tick(); tick();
    check("ins_en", en, E_0);
    check("ins_stat", bus.stat, 3'd4);
    check("ins_busy", bus.busy, 1'b0);

    // data-memory error reported together with ready
    do_reset();
    bus.icode = 4'd4; bus.instr_valid = 1'b1; bus.start = 1'b1;
    bus.mem_ready = 1'b1; bus.dmem_error = 1'b1;
    repeat (4) tick();
    check("dme_m", en, E_M);
    tick();
    check("dme_en", en, E_0);
    check("dme_stat", bus.stat, 3'd3);
    check("dme_ret", bus.retired, 0);

    // ---------------- async reset during MEMORY ----------------
    do_reset();
    bus.icode = 4'd6; bus.instr_valid = 1'b1; bus.start = 1'b1;
    repeat (5) tick();
    bus.icode = 4'd5;
    repeat (4) tick();
    check("ar_mem", en, E_M);
    check("ar_ret_pre", bus.retired, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_en", en, E_0);
    check("ar_stat", bus.stat, 3'd1);
    check("ar_ret", bus.retired, 0);
    check("ar_busy", bus.busy, 1'b0);
    #1 reset = 1'b0;
    bus.icode = 4'd2; bus.start = 1'b1;
    tick(); check("ar2_f", en, E_F);
    bus.start = 1'b0;
    repeat (5) tick();
    check("ar2_idle", en, E_0);
    check("ar2_ret", bus.retired, 1);
    check("ar2_stat", bus.stat, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
